// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU sequencer: opcodes, FSM state
// encoding and default operand width.
package alu_pkg;

   localparam int WIDTH = 16;
   localparam int CNT_W = 5;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      MUL  = 2'b10
   } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command side plus shared-adder side of the ALU sequencer, bundled so the
// ALU top (master) and the sequencer (slave) connect through one port.
interface alu_sequencer_if
   import alu_pkg::*;
#(
   parameter int W = WIDTH
);
   logic             start;
   logic [1:0]       opcode;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic             ready;
   logic             done;
   logic [2*W-1:0]   result;
   logic             illegal;
   logic [W-1:0]     add_op1;
   logic [W-1:0]     add_op2;
   logic             add_mode;
   logic [2*W-1:0]   add_result;

   modport master (
      output start, opcode, a, b, add_result,
      input  ready, done, result, illegal, add_op1, add_op2, add_mode
   );

   modport slave (
      input  start, opcode, a, b, add_result,
      output ready, done, result, illegal, add_op1, add_op2, add_mode
   );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: chooses the adder drive from {q[0], q_m1}
// and forms the arithmetically shifted {acc, q, q_m1} from the 17-bit sum.
module booth_step
   import alu_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic [W-1:0] acc_i,
   input  logic [W-1:0] q_i,
   input  logic         q_m1_i,
   input  logic [W-1:0] m_i,
   input  logic [W:0]   sum_i,
   output logic [W-1:0] op1_o,
   output logic [W-1:0] op2_o,
   output logic         mode_o,
   output logic [W-1:0] acc_o,
   output logic [W-1:0] q_o,
   output logic         q_m1_o
);

   // Booth recoding selects +M, -M or nothing for this bit pair.
   always_comb begin
      op1_o  = acc_i;
      op2_o  = {W{1'b0}};
      mode_o = 1'b0;
      case ({q_i[0], q_m1_i})
         2'b01: begin
            op2_o  = m_i;
            mode_o = 1'b0;
         end
         2'b10: begin
            op2_o  = m_i;
            mode_o = 1'b1;
         end
         default: begin
            op2_o  = {W{1'b0}};
            mode_o = 1'b0;
         end
      endcase
   end

   // sum_i[W] is the true sign, so the shift stays exact even when M = -2^(W-1).
   assign acc_o  = sum_i[W:1];
   assign q_o    = {sum_i[0], q_i[W-1:1]};
   assign q_m1_o = q_i[0];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU control: time-shares one external adder between ADD, SUB
// and 16-iteration signed Booth MUL; result/done/ready/illegal are registered.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int W     = WIDTH,
   parameter int CNT_W = alu_pkg::CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   alu_sequencer_if.slave bus
);

   state_e           state_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [1:0]       op_q;
   logic [W-1:0]     acc_q;
   logic [W-1:0]     mq_q;
   logic             qm1_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2*W-1:0]   result_q;
   logic             done_q;
   logic             illegal_q;
   logic             ready_q;

   logic [W-1:0]     acc_d;
   logic [W-1:0]     mq_d;
   logic             qm1_d;
   logic [W-1:0]     booth_op1_s;
   logic [W-1:0]     booth_op2_s;
   logic             booth_mode_s;
   logic [W-1:0]     add_op1_s;
   logic [W-1:0]     add_op2_s;
   logic             add_mode_s;

   booth_step #(.W(W)) u_booth (
      .acc_i  (acc_q),
      .q_i    (mq_q),
      .q_m1_i (qm1_q),
      .m_i    (b_q),
      .sum_i  (bus.add_result[W:0]),
      .op1_o  (booth_op1_s),
      .op2_o  (booth_op2_s),
      .mode_o (booth_mode_s),
      .acc_o  (acc_d),
      .q_o    (mq_d),
      .q_m1_o (qm1_d)
   );

   // Adder drive is a pure decode of registered state; idle and illegal commands park it at zero.
   always_comb begin
      add_op1_s  = {W{1'b0}};
      add_op2_s  = {W{1'b0}};
      add_mode_s = 1'b0;
      case (state_q)
         EXEC: begin
            if (op_q != OP_ILL) begin
               add_op1_s  = a_q;
               add_op2_s  = b_q;
               add_mode_s = op_q[0];
            end else begin
               add_op1_s  = {W{1'b0}};
               add_op2_s  = {W{1'b0}};
               add_mode_s = 1'b0;
            end
         end
         MUL: begin
            add_op1_s  = booth_op1_s;
            add_op2_s  = booth_op2_s;
            add_mode_s = booth_mode_s;
         end
         default: begin
            add_op1_s  = {W{1'b0}};
            add_op2_s  = {W{1'b0}};
            add_mode_s = 1'b0;
         end
      endcase
   end

   // Sequencer FSM with operand capture, Booth registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= {W{1'b0}};
         b_q       <= {W{1'b0}};
         op_q      <= 2'b00;
         acc_q     <= {W{1'b0}};
         mq_q      <= {W{1'b0}};
         qm1_q     <= 1'b0;
         cnt_q     <= {CNT_W{1'b0}};
         result_q  <= {(2*W){1'b0}};
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  op_q    <= bus.opcode;
                  ready_q <= 1'b0;
                  acc_q   <= {W{1'b0}};
                  mq_q    <= bus.a;
                  qm1_q   <= 1'b0;
                  cnt_q   <= {CNT_W{1'b0}};
                  state_q <= (bus.opcode == OP_MUL) ? MUL : EXEC;
               end
            end
            EXEC: begin
               result_q  <= (op_q == OP_ILL) ? {(2*W){1'b0}} : bus.add_result;
               illegal_q <= (op_q == OP_ILL);
               done_q    <= 1'b1;
               ready_q   <= 1'b1;
               state_q   <= IDLE;
            end
            MUL: begin
               acc_q <= acc_d;
               mq_q  <= mq_d;
               qm1_q <= qm1_d;
               cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_q == CNT_W'(W - 1)) begin
                  result_q <= {acc_d, mq_d};
                  done_q   <= 1'b1;
                  ready_q  <= 1'b1;
                  state_q  <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready    = ready_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.illegal  = illegal_q;
   assign bus.add_op1  = add_op1_s;
   assign bus.add_op2  = add_op2_s;
   assign bus.add_mode = add_mode_s;

endmodule
